// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing constants and shared coordinate type
package vga_pkg;

   typedef logic [9:0] coord_t;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FP      = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BP      = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FP      = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BP      = 33;

   localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   // Half-open interval test used for the sync pulse windows.
   function automatic logic in_window(coord_t v, int lo, int hi);
      return (v >= coord_t'(lo)) && (v < coord_t'(hi));
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - wrapping axis counter exposing its next value for registered decode
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int TOTAL = H_TOTAL
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [9:0] count,
   output logic [9:0] count_next,
   output logic       wrap
);

   localparam coord_t LAST = coord_t'(TOTAL - 1);

   always_comb begin
      wrap       = en && (count == LAST);
      count_next = count;
      if (wrap)
         count_next = '0;
      else if (en)
         count_next = count + 10'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else
         count <= count_next;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: counters, syncs, blank, frame pulses and frame count
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FP      = DEF_H_FP,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BP      = DEF_H_BP,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FP      = DEF_V_FP,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BP      = DEF_V_BP
)
(
   input  logic       vga_clk,
   input  logic       reset,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       frame_start,
   output logic       vblank_start,
   output logic [7:0] frame_count
);

   localparam int LINE_CLOCKS = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;

   coord_t hc, vc, hc_next, vc_next;
   logic   h_wrap, v_wrap;

   vga_axis_counter #(.TOTAL(LINE_CLOCKS)) u_hcount (
      .clk        (vga_clk),
      .rst        (reset),
      .en         (1'b1),
      .count      (hc),
      .count_next (hc_next),
      .wrap       (h_wrap)
   );

   vga_axis_counter #(.TOTAL(FRAME_LINES)) u_vcount (
      .clk        (vga_clk),
      .rst        (reset),
      .en         (h_wrap),
      .count      (vc),
      .count_next (vc_next),
      .wrap       (v_wrap)
   );

   // Decoding the next-state counters keeps every registered output aligned with DrawX/DrawY.
   logic hs_next, vs_next, blank_next, frame_start_next, vblank_start_next;

   always_comb begin
      hs_next           = !in_window(hc_next, H_VISIBLE + H_FP, H_VISIBLE + H_FP + H_SYNC);
      vs_next           = !in_window(vc_next, V_VISIBLE + V_FP, V_VISIBLE + V_FP + V_SYNC);
      blank_next        = (hc_next < coord_t'(H_VISIBLE)) && (vc_next < coord_t'(V_VISIBLE));
      frame_start_next  = v_wrap;
      vblank_start_next = (hc_next == '0) && (vc_next == coord_t'(V_VISIBLE));
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         hs           <= 1'b1;
         vs           <= 1'b1;
         blank        <= 1'b1;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         frame_count  <= '0;
      end else begin
         hs           <= hs_next;
         vs           <= vs_next;
         blank        <= blank_next;
         frame_start  <= frame_start_next;
         vblank_start <= vblank_start_next;
         if (frame_start_next)
            frame_count <= frame_count + 8'd1;
      end
   end

   assign DrawX = hc;
   assign DrawY = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen against an arithmetic raster model
module tb_vga_timing_gen;

   localparam int S_HV = 12, S_HFP = 2, S_HSY = 3, S_HBP = 3;
   localparam int S_VV = 6,  S_VFP = 1, S_VSY = 2, S_VBP = 1;
   localparam int S_FRAME = (S_HV + S_HFP + S_HSY + S_HBP) * (S_VV + S_VFP + S_VSY + S_VBP);

   typedef struct {
      int x, y, fc;
      bit hs, vs, blank, fs, vb;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       d_hs, d_vs, d_blank, d_fs, d_vb;
   logic [9:0] d_x, d_y;
   logic [7:0] d_fc;
   logic       s_hs, s_vs, s_blank, s_fs, s_vb;
   logic [9:0] s_x, s_y;
   logic [7:0] s_fc;

   int     checks = 0;
   int     failures = 0;
   longint t;
   bit     check_en = 1'b0;

   always #20 clk = ~clk;

   vga_timing_gen dut_d (
      .vga_clk(clk), .reset(reset), .hs(d_hs), .vs(d_vs), .blank(d_blank),
      .DrawX(d_x), .DrawY(d_y), .frame_start(d_fs), .vblank_start(d_vb), .frame_count(d_fc)
   );

   vga_timing_gen #(
      .H_VISIBLE(S_HV), .H_FP(S_HFP), .H_SYNC(S_HSY), .H_BP(S_HBP),
      .V_VISIBLE(S_VV), .V_FP(S_VFP), .V_SYNC(S_VSY), .V_BP(S_VBP)
   ) dut_s (
      .vga_clk(clk), .reset(reset), .hs(s_hs), .vs(s_vs), .blank(s_blank),
      .DrawX(s_x), .DrawY(s_y), .frame_start(s_fs), .vblank_start(s_vb), .frame_count(s_fc)
   );

   // Clocks elapsed since reset release; every expected output is pure arithmetic on this.
   always @(posedge clk or posedge reset) begin
      if (reset) t <= 0;
      else       t <= t + 1;
   end

   function automatic exp_t model(longint tt, int hv, int hfp, int hsy, int hbp,
                                  int vv, int vfp, int vsy, int vbp);
      exp_t   e;
      longint ht = hv + hfp + hsy + hbp;
      longint vt = vv + vfp + vsy + vbp;
      e.x     = int'(tt % ht);
      e.y     = int'((tt / ht) % vt);
      e.fc    = int'((tt / (ht * vt)) % 256);
      e.hs    = !(e.x >= hv + hfp && e.x < hv + hfp + hsy);
      e.vs    = !(e.y >= vv + vfp && e.y < vv + vfp + vsy);
      e.blank = (e.x < hv) && (e.y < vv);
      e.fs    = (tt > 0) && (tt % (ht * vt) == 0);
      e.vb    = (e.x == 0) && (e.y == vv);
      return e;
   endfunction

   task automatic cmp(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s t=%0d got=%0d expected=%0d", name, t, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         exp_t ed, es;
         ed = model(t, 640, 16, 96, 48, 480, 10, 2, 33);
         es = model(t, S_HV, S_HFP, S_HSY, S_HBP, S_VV, S_VFP, S_VSY, S_VBP);
         cmp("d_DrawX", d_x, ed.x);       cmp("d_DrawY", d_y, ed.y);
         cmp("d_hs", d_hs, ed.hs);        cmp("d_vs", d_vs, ed.vs);
         cmp("d_blank", d_blank, ed.blank);
         cmp("d_frame_start", d_fs, ed.fs);
         cmp("d_vblank_start", d_vb, ed.vb);
         cmp("d_frame_count", d_fc, ed.fc);
         cmp("s_DrawX", s_x, es.x);       cmp("s_DrawY", s_y, es.y);
         cmp("s_hs", s_hs, es.hs);        cmp("s_vs", s_vs, es.vs);
         cmp("s_blank", s_blank, es.blank);
         cmp("s_frame_start", s_fs, es.fs);
         cmp("s_vblank_start", s_vb, es.vb);
         cmp("s_frame_count", s_fc, es.fc);
      end
   end

   task automatic run_to(longint target);
      for (int i = 0; i < 200000 && t < target; i++) @(negedge clk);
      cmp("run_to_reached", t, target);
   endtask

   task automatic check_reset_values(string tag);
      cmp({tag, "_DrawX"}, s_x, 0);        cmp({tag, "_DrawY"}, s_y, 0);
      cmp({tag, "_hs"}, s_hs, 1);          cmp({tag, "_vs"}, s_vs, 1);
      cmp({tag, "_blank"}, s_blank, 1);    cmp({tag, "_fs"}, s_fs, 0);
      cmp({tag, "_vb"}, s_vb, 0);          cmp({tag, "_fc"}, s_fc, 0);
   endtask

   task automatic pulse_reset(int offset, int hold);
      @(negedge clk);
      #(offset) reset = 1'b1;
      #1 check_reset_values("rst_async");
      repeat (hold) @(negedge clk);
      #(offset) reset = 1'b0;
   endtask

   int fs_seen, vb_seen, vs_low, blank_hi, bad_blank;

   initial begin
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check_en = 1'b1;
      #5 reset = 1'b0;
      #1;
      cmp("init_DrawX", d_x, 0);   cmp("init_DrawY", d_y, 0);
      cmp("init_hs", d_hs, 1);     cmp("init_vs", d_vs, 1);
      cmp("init_blank", d_blank, 1);
      cmp("init_fs", d_fs, 0);     cmp("init_fc", d_fc, 0);

      // One line of the default timing, pinned to hand-derived edges.
      run_to(639); cmp("blank_639", d_blank, 1);
      run_to(640); cmp("blank_640", d_blank, 0);
      run_to(655); cmp("hs_655", d_hs, 1);
      run_to(656); cmp("hs_656", d_hs, 0);
      run_to(751); cmp("hs_751", d_hs, 0);
      run_to(752); cmp("hs_752", d_hs, 1);
      run_to(799); cmp("x_799", d_x, 799); cmp("y_799", d_y, 0);
      run_to(800); cmp("x_800", d_x, 0);   cmp("y_800", d_y, 1);
      cmp("blank_800", d_blank, 1);

      // Reset landing at small-DUT (5,3), held 3 cycles.
      pulse_reset(2, 0);
      run_to(3 * 20 + 5);
      cmp("pre_x", s_x, 5); cmp("pre_y", s_y, 3);
      pulse_reset(3, 3);
      @(negedge clk);
      cmp("post_x", s_x, 1); cmp("post_y", s_y, 0); cmp("post_fs", s_fs, 0);

      // Random run lengths with asynchronous resets at random sub-cycle offsets.
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(50, 600)) @(negedge clk);
         pulse_reset($urandom_range(1, 15), $urandom_range(1, 4));
      end

      // 256 frames of the reduced timing with aggregate counts.
      pulse_reset(5, 2);
      fs_seen = 0; vb_seen = 0; vs_low = 0; blank_hi = 0; bad_blank = 0;
      for (int c = 1; c <= 256 * S_FRAME; c++) begin
         @(negedge clk);
         if (s_fs) fs_seen++;
         if (s_vb) vb_seen++;
         if (!s_vs) vs_low++;
         if (s_blank) begin
            blank_hi++;
            if (s_x >= 10'(S_HV) || s_y >= 10'(S_VV)) bad_blank++;
         end
         if (c == S_FRAME)       cmp("fc_after_1", s_fc, 1);
         if (c == 255 * S_FRAME) cmp("fc_after_255", s_fc, 255);
      end
      cmp("fc_after_256", s_fc, 0);
      cmp("frame_start_count", fs_seen, 256);
      cmp("vblank_start_count", vb_seen, 256);
      cmp("vs_low_cycles", vs_low, 256 * 40);
      cmp("blank_cycles", blank_hi, 256 * 72);
      cmp("blank_outside_visible", bad_blank, 0);

      check_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

- Generates 640x480 @ 60 Hz VGA raster timing from the 25 MHz pixel clock: horizontal and vertical counters, active-low sync pulses, the active-high display-enable `blank`, and the `DrawX`/`DrawY` pixel coordinates.
- Drives every sprite/background renderer and palette stage downstream.
- Also provides frame-level pulses and a frame counter so game logic can update state once per frame during vertical blanking.

## Interface
Parameters (defaults from `vga_pkg`):
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BP`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `vga_clk` in, 1 bit, 25 MHz pixel clock; sole clock.
- `reset` in, 1 bit, asynchronous, active-high.
- `hs` out, 1 bit, horizontal sync, active-low.
- `vs` out, 1 bit, vertical sync, active-low.
- `blank` out, 1 bit, 1 = visible pixel (renderers drive colour only when high), 0 = blanking.
- `DrawX` out, 10 bits, current horizontal count.
- `DrawY` out, 10 bits, current vertical count.
- `frame_start` out, 1 bit, one-cycle pulse on frame wrap.
- `vblank_start` out, 1 bit, one-cycle pulse at first blank line.
- `frame_count` out, 8 bits, completed-frame counter.

## Operation
- Derived totals: H_TOTAL = 800 and V_TOTAL = 525 (each is the sum of its four timing parameters).
- Horizontal counter `hc` (0..H_TOTAL-1):
  - Increments every clock.
  - At H_TOTAL-1 it wraps to 0, and `vc` advances.
- Vertical counter `vc` (0..V_TOTAL-1):
  - Increments only on `hc` wrap.
  - On `hc` wrap while `vc` = V_TOTAL-1, it wraps to 0.
- `DrawX` = `hc` and `DrawY` = `vc`. Both carry the full range, including blanking values; renderers mask them with `blank`.
- `hs` = 0 iff H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751 at defaults).
- `vs` = 0 iff V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491).
- `blank` = 1 iff hc < H_VISIBLE and vc < V_VISIBLE.
- `frame_start`:
  - 1 for exactly the cycle in which counters read (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted for the (0,0) that follows reset release.
- `vblank_start` = 1 for the single cycle with (hc,vc) = (0, V_VISIBLE).
- `frame_count`:
  - Increments by 1 in the cycle `frame_start` is asserted.
  - 8-bit, wraps 255 -> 0 with no flag.
- Reset values: `hc` = 0, `vc` = 0, `hs` = 1, `vs` = 1, `blank` = 1, `DrawX` = 0, `DrawY` = 0, `frame_start` = 0, `vblank_start` = 0, `frame_count` = 0.
- Reset asserted mid-frame: all state returns to the reset values immediately (asynchronously). Counting resumes at (0,0) on the first `vga_clk` edge after deassertion; that edge moves the counters to (1,0).

## Timing
- All outputs are registered and mutually aligned: in any cycle, `hs`/`vs`/`blank`/pulses are the decode of the `DrawX`/`DrawY` values presented in that same cycle. Implement this by decoding the next-state counters.
- Downstream ROMs sample on negedge, so outputs must settle within half a period after posedge. No combinational path from inputs to outputs.
- Line period: 800 clocks. Frame period: 420,000 clocks.
- Simultaneous events:
  - At (799,524) -> (0,0), `hc` wrap, `vc` wrap, `frame_start` and the `frame_count` increment all occur on the same edge.
  - `vblank_start` never coincides with `frame_start`.
- Parameters are elaboration-time only. No runtime mode switching.

## Structure
- `vga_pkg`:
  - Default timing constants.
  - Derived H_TOTAL/V_TOTAL as localparams.
  - `typedef logic [9:0] coord_t`, shared with all renderers.
- One sub-module, `vga_axis_counter`: a parameterised wrapping counter with enable and a wrap output, instantiated once for the horizontal axis and once for the vertical axis (enable = horizontal wrap).
- Sync, blank and pulse decode live in the top level.

## Test plan
- Reset then release: first cycle shows DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0, frame_count=0.
- Run one line: hs falls at DrawX=656 and rises at DrawX=752; blank falls at DrawX=640; DrawY goes 0->1 on the edge after DrawX=799.
- Run one full frame: vblank_start pulses once at (0,480); vs is low for exactly 1600 clocks (lines 490–491); frame_start pulses once at the wrap, after 420,000 clocks; frame_count = 1.
- Run 256 frames: frame_count reads 255 then wraps to 0; frame_start is seen 256 times.
- Assert reset at (300,200) for 3 cycles: outputs immediately match the reset values; after release, counting restarts from (0,0) with no spurious frame_start.
- Blank coverage: scan a frame and confirm blank=1 for exactly 307,200 cycles, never when DrawX>=640 or DrawY>=480.
